// File: rtl/mem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM encodings, port indices, default sizes.
package mem_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Two-way request picker. MEM_ARB_RR_EN selects round-robin on ties; otherwise port 0 has fixed priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

  // Winner selection; with no request the previous grant is simply echoed back.
  always_comb begin
    winner = last;
`ifdef MEM_ARB_RR_EN
    if (req0 && req1) begin
      winner = ~last;
    end else if (req0) begin
      winner = PORT0;
    end else if (req1) begin
      winner = PORT1;
    end else begin
      winner = last;
    end
`else
    if (req0) begin
      winner = PORT0;
    end else if (req1) begin
      winner = PORT1;
    end else begin
      winner = last;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Data memory shared by the core (port 0) and the loader/debug port (port 1); one access per 3 cycles.
// Tie-breaking is round-robin when MEM_ARB_RR_EN is defined, fixed port-0 priority otherwise.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];

  state_t            state_r;
  logic              last_r;
  logic              sel_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              gnt0_r, gnt1_r, done0_r, done1_r;
  logic [DATA_W-1:0] rdata_r;

  logic              winner_s;
  logic              any_req_s;
  logic              req_we_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic [DATA_W-1:0] req_wdata_s;

  arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_r),
    .winner (winner_s)
  );

  // Route the winning port's command toward the capture registers.
  always_comb begin
    any_req_s   = req0 | req1;
    req_we_s    = we0;
    req_addr_s  = addr0;
    req_wdata_s = wdata0;
    if (winner_s == PORT1) begin
      req_we_s    = we1;
      req_addr_s  = addr1;
      req_wdata_s = wdata1;
    end else begin
      req_we_s    = we0;
      req_addr_s  = addr0;
      req_wdata_s = wdata0;
    end
  end

  // Arbitration FSM: capture in IDLE, access in ACCESS, completion pulse in RESP.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_r <= ST_IDLE;
      last_r  <= PORT1;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            sel_r   <= winner_s;
            we_r    <= req_we_s;
            addr_r  <= req_addr_s;
            wdata_r <= req_wdata_s;
            last_r  <= winner_s;
            gnt0_r  <= (winner_s == PORT0);
            gnt1_r  <= (winner_s == PORT1);
            state_r <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (!we_r) begin
            rdata_r <= mem_r[addr_r];
          end
          done0_r <= (sel_r == PORT0);
          done1_r <= (sel_r == PORT1);
          state_r <= ST_RESP;
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory is never cleared; a reset landing on the ACCESS edge drops the pending store.
  always_ff @(posedge Clock) begin
    if (Resetn && (state_r == ST_ACCESS) && we_r) begin
      mem_r[addr_r] <= wdata_r;
    end
  end

  assign gnt0  = gnt0_r;
  assign gnt1  = gnt1_r;
  assign done0 = done0_r;
  assign done1 = done1_r;
  assign rdata = rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expected grant order follows MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  logic        Clock;
  logic        Resetn;
  logic        req0, req1, we0, we1;
  logic [3:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] rdata;

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .req0   (req0),
    .req1   (req1),
    .we0    (we0),
    .we1    (we1),
    .addr0  (addr0),
    .addr1  (addr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .rdata  (rdata)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle and check the four handshake outputs.
  task automatic step_chk(input string tag, input logic g0, input logic g1,
                          input logic d0, input logic d1);
    @(posedge Clock);
    #1;
    chk({tag, "_gnt0"},  {15'd0, gnt0},  {15'd0, g0});
    chk({tag, "_gnt1"},  {15'd0, gnt1},  {15'd0, g1});
    chk({tag, "_done0"}, {15'd0, done0}, {15'd0, d0});
    chk({tag, "_done1"}, {15'd0, done1}, {15'd0, d1});
  endtask

  task automatic access(input string tag, input logic port, input logic we,
                        input logic [3:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rd);
    if (port == 1'b0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end
    step_chk({tag, "_g"}, ~port, port, 1'b0, 1'b0);
    // Scramble the command after grant; the captured copy must be used.
    req0 = 1'b0; req1 = 1'b0;
    we0 = ~we; we1 = ~we; addr0 = ~addr; addr1 = ~addr; wdata0 = ~wdata; wdata1 = ~wdata;
    step_chk({tag, "_d"}, 1'b0, 1'b0, ~port, port);
    if (!we) begin
      chk({tag, "_rdata"}, rdata, exp_rd);
    end
    step_chk({tag, "_i"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic p;
    // 1: reset with both ports requesting
    Resetn = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd0; wdata0 = 16'hDEAD;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd0; wdata1 = 16'hBEEF;
    step_chk("t1_rst_a", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_rdata_a", rdata, 16'h0000);
    step_chk("t1_rst_b", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_rdata_b", rdata, 16'h0000);
    req0 = 1'b0; req1 = 1'b0;
    Resetn = 1'b1;

    // 2: store then load on port 0
    access("t2_st", 1'b0, 1'b1, 4'd5, 16'h00AB, 16'h0000);
    access("t2_ld", 1'b0, 1'b0, 4'd5, 16'h0000, 16'h00AB);

    // 3: simultaneous load (port 0) and store (port 1) to the same address
    access("t3_pre", 1'b1, 1'b1, 4'd3, 16'h0033, 16'h0000);
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3; wdata0 = 16'h0000;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd3; wdata1 = 16'h0004;
    step_chk("t3_g0", 1'b1, 1'b0, 1'b0, 1'b0);
    req0 = 1'b0;
    step_chk("t3_d0", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_old", rdata, 16'h0033);
    step_chk("t3_i0", 1'b0, 1'b0, 1'b0, 1'b0);
    step_chk("t3_g1", 1'b0, 1'b1, 1'b0, 1'b0);
    req1 = 1'b0;
    step_chk("t3_d1", 1'b0, 1'b0, 1'b0, 1'b1);
    step_chk("t3_i1", 1'b0, 1'b0, 1'b0, 1'b0);
    access("t3_ld", 1'b0, 1'b0, 4'd3, 16'h0000, 16'h0004);

    // 5: reset during the ACCESS cycle of a store
    access("t5_pre", 1'b0, 1'b1, 4'd7, 16'h1111, 16'h0000);
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd7; wdata0 = 16'h2222;
    step_chk("t5_g", 1'b1, 1'b0, 1'b0, 1'b0);
    Resetn = 1'b0;
    req0 = 1'b0;
    step_chk("t5_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_rdata_rst", rdata, 16'h0000);
    Resetn = 1'b1;
    step_chk("t5_nodone", 1'b0, 1'b0, 1'b0, 1'b0);
    access("t5_ld", 1'b0, 1'b0, 4'd7, 16'h0000, 16'h1111);

    // 6: top address does not alias address 0
    access("t6_st0", 1'b1, 1'b1, 4'd0, 16'h0000, 16'h0000);
    access("t6_st15", 1'b1, 1'b1, 4'd15, 16'hFFFF, 16'h0000);
    access("t6_ld0", 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
    access("t6_ld15", 1'b1, 1'b0, 4'd15, 16'h0000, 16'hFFFF);

    // Reset again with stores pending so the tie pointer is back at its reset value
    Resetn = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd0; wdata0 = 16'hDEAD;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd0; wdata1 = 16'hBEEF;
    step_chk("r2_rst_a", 1'b0, 1'b0, 1'b0, 1'b0);
    step_chk("r2_rst_b", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("r2_rdata", rdata, 16'h0000);
    req0 = 1'b0; req1 = 1'b0;
    Resetn = 1'b1;

    // 4: both ports held for six accesses
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd15;
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
      p = i[0];
`else
      p = 1'b0;
`endif
      step_chk($sformatf("t4_g%0d", i), ~p, p, 1'b0, 1'b0);
      if (i == 5) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      step_chk($sformatf("t4_d%0d", i), 1'b0, 1'b0, ~p, p);
      chk($sformatf("t4_rd%0d", i), rdata, p ? 16'hFFFF : 16'h0000);
      step_chk($sformatf("t4_i%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Address 0 must still hold 0 after the stores issued under reset
    access("r2_ld0", 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
